// File: rtl/greensc_pkg.sv
// Shared types and constants for the green-screen keyer controller.
// The GSC_CTRL_SCROLL_EN build option uses bg_next() for the background scroll.
package greensc_pkg;

  typedef enum logic [1:0] {
    StOff,
    StArmOn,
    StOn,
    StArmOff
  } gsc_state_e;

  localparam logic [8:0] HUE_MAX         = 9'd359;
  localparam logic [9:0] HUE_MOD         = 10'd360;
  localparam logic [8:0] HUE_LO_DEF      = 9'd90;
  localparam logic [8:0] HUE_HI_DEF      = 9'd150;
  localparam logic [8:0] HUE_STEP_DEF    = 9'd5;
  localparam logic [8:0] SCROLL_STEP_DEF = 9'd1;

  // Single conditional subtract: step is assumed to be below HUE_MOD.
  function automatic logic [8:0] bg_next(input logic [8:0] cur, input logic [8:0] step);
    logic [9:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= HUE_MOD) begin
      sum = sum - HUE_MOD;
    end
    return sum[8:0];
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector for an already-synchronous level input.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  logic r_key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= 1'b0;
    end else begin
      r_key_q <= key;
    end
  end

  assign pulse = key & ~r_key_q;

endmodule

// File: rtl/greensc_ctrl.sv
// Frame-synchronous enable and hue-window controller for the green-screen keyer.
// Define GSC_CTRL_SCROLL_EN to build the per-frame background hue scroll.
module greensc_ctrl
  import greensc_pkg::*;
#(
  parameter logic [8:0] HUE_LO_RST  = HUE_LO_DEF,
  parameter logic [8:0] HUE_HI_RST  = HUE_HI_DEF,
  parameter logic [8:0] HUE_STEP    = HUE_STEP_DEF,
  parameter logic [8:0] SCROLL_STEP = SCROLL_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] row,
  input  logic [12:0] col,
  input  logic        key_toggle,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        sel_hi,
  output logic        gsc_en,
  output logic [8:0]  hue_lo,
  output logic [8:0]  hue_hi,
  output logic [8:0]  bg_offset,
  output logic        frame_start,
  output logic        pending
);

  gsc_state_e r_state;
  gsc_state_e w_state_d;
  logic [8:0] r_sh_lo, r_sh_hi;
  logic [8:0] w_sh_lo_d, w_sh_hi_d, w_hue_lo_d, w_hue_hi_d;
  logic       w_tog, w_up_edge, w_dn_edge, w_up, w_dn, w_fs, w_en_d;
  logic [9:0] w_lo_ext, w_hi_ext, w_step_ext;
  logic [9:0] w_lo_up, w_lo_dn, w_hi_up, w_hi_dn;

  key_edge u_edge_toggle (.clk(clk), .rst_n(rst_n), .key(key_toggle), .pulse(w_tog));
  key_edge u_edge_up     (.clk(clk), .rst_n(rst_n), .key(key_up),     .pulse(w_up_edge));
  key_edge u_edge_down   (.clk(clk), .rst_n(rst_n), .key(key_down),   .pulse(w_dn_edge));

  assign w_fs = (row == 13'd0) && (col == 13'd0);
  // Simultaneous up and down edges cancel each other.
  assign w_up = w_up_edge & ~w_dn_edge;
  assign w_dn = w_dn_edge & ~w_up_edge;

  assign w_lo_ext   = {1'b0, r_sh_lo};
  assign w_hi_ext   = {1'b0, r_sh_hi};
  assign w_step_ext = {1'b0, HUE_STEP};
  assign w_lo_up    = w_lo_ext + w_step_ext;
  assign w_lo_dn    = w_lo_ext - w_step_ext;
  assign w_hi_up    = w_hi_ext + w_step_ext;
  assign w_hi_dn    = w_hi_ext - w_step_ext;

  always_comb begin
    w_sh_lo_d = r_sh_lo;
    w_sh_hi_d = r_sh_hi;
    if (w_up && !sel_hi) begin
      w_sh_lo_d = (w_lo_up > w_hi_ext) ? r_sh_hi : w_lo_up[8:0];
    end else if (w_dn && !sel_hi) begin
      w_sh_lo_d = (w_lo_ext < w_step_ext) ? 9'd0 : w_lo_dn[8:0];
    end else if (w_up && sel_hi) begin
      w_sh_hi_d = (w_hi_up > {1'b0, HUE_MAX}) ? HUE_MAX : w_hi_up[8:0];
    end else if (w_dn && sel_hi) begin
      // Floor at the lower shadow bound keeps lo <= hi.
      w_sh_hi_d = (w_hi_ext < (w_step_ext + w_lo_ext)) ? r_sh_lo : w_hi_dn[8:0];
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StOff:    if (w_tog) w_state_d = StArmOn;
      StArmOn:  if (w_tog) w_state_d = StOff; else if (w_fs) w_state_d = StOn;
      StOn:     if (w_tog) w_state_d = StArmOff;
      StArmOff: if (w_tog) w_state_d = StOn;  else if (w_fs) w_state_d = StOff;
      default:  w_state_d = StOff;
    endcase
  end

  // Commit takes the shadow as it stood before any adjust edge in the FS cycle.
  assign w_hue_lo_d = w_fs ? r_sh_lo : hue_lo;
  assign w_hue_hi_d = w_fs ? r_sh_hi : hue_hi;
  assign w_en_d     = (w_state_d == StOn) || (w_state_d == StArmOff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StOff;
      gsc_en      <= 1'b0;
      frame_start <= 1'b0;
      pending     <= 1'b0;
      hue_lo      <= HUE_LO_RST;
      hue_hi      <= HUE_HI_RST;
      r_sh_lo     <= HUE_LO_RST;
      r_sh_hi     <= HUE_HI_RST;
    end else begin
      r_state     <= w_state_d;
      gsc_en      <= w_en_d;
      frame_start <= w_fs;
      pending     <= (w_state_d == StArmOn) || (w_state_d == StArmOff) ||
                     (w_sh_lo_d != w_hue_lo_d) || (w_sh_hi_d != w_hue_hi_d);
      hue_lo      <= w_hue_lo_d;
      hue_hi      <= w_hue_hi_d;
      r_sh_lo     <= w_sh_lo_d;
      r_sh_hi     <= w_sh_hi_d;
    end
  end

`ifdef GSC_CTRL_SCROLL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_offset <= 9'd0;
    end else if (w_fs && w_en_d) begin
      bg_offset <= bg_next(bg_offset, SCROLL_STEP);
    end
  end
`else
  logic w_unused_scroll;
  assign w_unused_scroll = ^SCROLL_STEP;
  assign bg_offset       = 9'd0;
`endif

endmodule

// File: doc/greensc_ctrl.md
# greensc_ctrl

Frame-synchronous controller for the green-screen keyer. It turns pushbutton-level requests into a tear-free `gsc_en` and maintains the keyer's hue window (`hue_lo`/`hue_hi`) from up/down adjust keys. It also produces a per-frame scrolling background hue offset. It sits between the key/switch inputs and the green-screen datapath, and is clocked by the pixel clock alongside the `row`/`col` scan counters.

## Interface
- `HUE_LO_RST`, 9'd90: reset/default lower hue bound.
- `HUE_HI_RST`, 9'd150: reset/default upper hue bound.
- `HUE_STEP`, 9'd5: adjust increment per key press.
- `SCROLL_STEP`, 9'd1: background offset advance per frame.
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `row` in 13: current scan row.
- `col` in 13: current scan column.
- `key_toggle` in 1: level, active-high, already synchronous; each rising edge requests an enable toggle.
- `key_up` in 1: level; each rising edge raises the selected bound.
- `key_down` in 1: level; each rising edge lowers the selected bound.
- `sel_hi` in 1: 0 selects `hue_lo` for adjustment, 1 selects `hue_hi`.
- `gsc_en` out 1: keyer enable; changes only at frame start.
- `hue_lo` out 9: committed lower bound, 0..359.
- `hue_hi` out 9: committed upper bound, 0..359.
- `bg_offset` out 9: background hue offset, 0..359.
- `frame_start` out 1: one-cycle pulse, registered.
- `pending` out 1: high while a toggle or a bound change awaits commit.

## Operation
- Edge detect: `edge = key & ~key_q`, with `key_q` registered. A held key produces exactly one event.
- Frame start condition (FS): `row == 0 && col == 0`, sampled every cycle.
- FSM states:
  - OFF: toggle → ARM_ON.
  - ARM_ON: FS → ON. Toggle → OFF (cancel). Toggle has priority over a simultaneous FS.
  - ON: toggle → ARM_OFF.
  - ARM_OFF: FS → OFF. Toggle → ON (cancel). Toggle has priority over a simultaneous FS.
- `gsc_en` is 1 in ON and ARM_OFF, 0 in OFF and ARM_ON.
- Shadow bounds `sh_lo`/`sh_hi` update immediately on an up/down edge. Arithmetic is done in 10 bits:
  - lo up: `min(sh_lo + STEP, sh_hi)`.
  - lo down: `max(sh_lo − STEP, 0)`.
  - hi up: `min(sh_hi + STEP, 359)`.
  - hi down: `max(sh_hi − STEP, sh_lo)`.
- The invariant `sh_lo <= sh_hi` always holds.
- Up and down edges in the same cycle: both ignored.
- A `sel_hi` change applies to the next edge only.
- At FS: `hue_lo ← sh_lo` and `hue_hi ← sh_hi`. An adjust edge in the FS cycle updates the shadow only and commits at the next FS.
- `pending` = (state ∈ {ARM_ON, ARM_OFF}) or (shadow ≠ committed).
- Reset values:
  - state OFF.
  - `gsc_en` 0.
  - `hue_lo` and `sh_lo` = `HUE_LO_RST`.
  - `hue_hi` and `sh_hi` = `HUE_HI_RST`.
  - `bg_offset` 0, `frame_start` 0, `pending` 0, `key_q` 0.
- A reset mid-frame clears all of the above immediately; no partial commit survives.

## Timing
- All outputs are registered. They change on the clock edge that samples FS, so they are visible one cycle after the FS cycle. `frame_start` is high for exactly that one cycle.
- Toggle latency: from the cycle the toggle edge is seen to the `gsc_en` change is 1 + (cycles until the next FS). If FS and the toggle occur in the same cycle in OFF, the enable waits a full frame.
- Shadow update latency is one cycle. Committed-bound latency is until the next FS.
- `bg_offset`: at FS while the post-transition state is ON or ARM_OFF, it becomes `(bg_offset + SCROLL_STEP) mod 360`. The sum is computed in 10 bits and 360 is subtracted if ≥ 360 (for example, 359 + 1 → 0). In OFF and ARM_ON it holds its value.

## Configuration
- `GSC_CTRL_SCROLL_EN` defined: `bg_offset` advances as described.
- `GSC_CTRL_SCROLL_EN` not defined: `bg_offset` is constant 0, no scroll register is built, and `SCROLL_STEP` is unused.

## Structure
- Package `greensc_pkg` holds:
  - the state enum (OFF, ARM_ON, ON, ARM_OFF);
  - `HUE_MAX = 9'd359`;
  - `HUE_MOD = 10'd360`;
  - the default bound constants.
- One sub-module, `key_edge` (registered rising-edge detector with async active-low reset), is instantiated three times: toggle, up, down.

## Test plan
- Reset, then run 2 frames with no keys → `gsc_en` = 0, `hue_lo` = 90, `hue_hi` = 150, `bg_offset` = 0, and `frame_start` pulses once per frame.
- Toggle pulse mid-frame → `pending` = 1, and `gsc_en` rises exactly one cycle after the next (0,0). A second toggle before that FS → returns to OFF, `gsc_en` never rises.
- With `sel_hi` = 0, press up 13 times from lo = 90, hi = 150 → `sh_lo` = 150 (clamped). `hue_lo` stays 90 until the next FS, then becomes 150.
- With `sel_hi` = 1, hi = 355, press up → 359. Press up again → 359. Hold `key_up` for 100 cycles → a single step only.
- With `GSC_CTRL_SCROLL_EN`, ON, `bg_offset` = 358, run 3 frames → 359, 0, 1. Without the macro → 0 throughout.
- Assert `rst_n` low mid-frame in ARM_OFF with a pending bound change → all outputs return to their reset values immediately, and no commit occurs at the following FS.
